fifo_axis_reader: RTL and testbench
===================================

# fifo_axis_reader

Drain side of the sync FIFO. Pops words from a first-word-fall-through FIFO read port and presents them as an AXI4-Stream master, with backpressure and fixed-length packet framing (`tlast`). Sits between a `sync_fifo` instance and any downstream stream consumer (DMA, serializer, packetizer). A 2-entry output buffer gives full throughput with no combinational path from `m_axis_tready` to `o_fifo_rd_en`.

## Interface
- DATA_WIDTH, 8, width of FIFO word and `m_axis_tdata`
- LEN_WIDTH, 16, width of packet length input and beat counter
- i_clk  in  1  clock; all logic on rising edge
- i_s_rst  in  1  synchronous reset, active-high
- i_enable  in  1  allow new FIFO pops; buffered words drain regardless
- i_packet_len  in  LEN_WIDTH  beats per packet; 0 is treated as 1
- o_fifo_rd_en  out  1  pop request to FIFO
- i_fifo_rd_data  in  DATA_WIDTH  FIFO head word, valid whenever `i_fifo_empty` = 0
- i_fifo_empty  in  1  FIFO empty flag
- m_axis_tdata  out  DATA_WIDTH  stream data
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tlast  out  1  last beat of packet
- o_packet_done  out  1  one-cycle pulse after each `tlast` handshake
- o_busy  out  1  words buffered or packet in progress

## Operation
- One clock; reset is synchronous and active-high (`i_clk`, `i_s_rst`).
- Buffer: two registered slots, `slot0` (drives `m_axis_tdata`) and `slot1` (skid), plus `occ` ∈ {0,1,2}.
- Pop rule: `o_fifo_rd_en` = `i_enable` & ~`i_fifo_empty` & (`occ` < 2) & ~`i_s_rst`. It depends only on registers and FIFO flags, never on `m_axis_tready`.
- On a pop, `i_fifo_rd_data` is captured in the same cycle.
- Handshake `hs` = `m_axis_tvalid` & `m_axis_tready`. `m_axis_tvalid` = (`occ` != 0).
- Next-state by (pop, hs):
  - pop, no hs: word goes to `slot0` if `occ`=0, otherwise to `slot1`; `occ`+1.
  - hs, no pop: `slot1`→`slot0`; `occ`−1.
  - pop and hs: if `occ`=1, the new word goes to `slot0`; if `occ`=2, `slot1`→`slot0` and the new word goes to `slot1`. `occ` is unchanged.
- Order is strictly FIFO. No word is ever dropped or duplicated outside reset.
- Framing:
  - `beat_cnt` (LEN_WIDTH) increments on each `hs`. It clears to 0 on a `tlast` handshake.
  - `len_q` captures the effective length on the first-beat handshake (`beat_cnt`=0).
  - Effective length: `eff_len` = (`beat_cnt`=0 ? `i_packet_len` : `len_q`), with 0 mapped to 1.
  - `m_axis_tlast` = `m_axis_tvalid` & (`beat_cnt` = `eff_len` − 1).
  - `i_packet_len` changes mid-packet are ignored.
- `o_packet_done`: registered; high for one cycle after the cycle with `hs` & `m_axis_tlast`.
- `o_busy` = (`occ` != 0) | (`beat_cnt` != 0).
- `i_enable` low: no pops. Words already in `slot0`/`slot1` still complete their handshakes. `beat_cnt` is preserved, so the packet resumes when `i_enable` returns.

## Timing
- Reset values: `m_axis_tvalid` 0, `m_axis_tdata` 0, `m_axis_tlast` 0, `o_fifo_rd_en` 0, `o_packet_done` 0, `o_busy` 0. Internal `occ` = 0, `beat_cnt` = 0, `len_q` = 0.
- Latency: pop in cycle N (`occ` = 0) → `m_axis_tvalid` = 1 with that word in cycle N+1.
- Throughput: with `m_axis_tready` held at 1 and the FIFO non-empty, one beat per cycle; `occ` stays at 1.
- Backpressure:
  - `m_axis_tready` drops with `occ`=1 and a pop in flight: `occ` → 2 and pops stop.
  - `m_axis_tready` returns: beats resume on the next cycle with no bubble. Pops resume once `occ` < 2.
- AXIS rules: once `m_axis_tvalid` = 1, `m_axis_tvalid`, `m_axis_tdata` and `m_axis_tlast` stay stable until `hs`.
- `m_axis_tlast` is combinational from registers plus `i_packet_len`, and only while `beat_cnt` = 0.
- Reset mid-operation: buffered words are discarded (already popped from the FIFO and lost), `beat_cnt` clears, and the next beat starts a new packet.
- FIFO empty: `occ` drains to 0 and `m_axis_tvalid` falls the cycle after the last `hs`. A partial packet stays open with `beat_cnt` held.

## Test plan
- Reset then FIFO loaded with 0x01..0x08, `i_packet_len`=4, `m_axis_tready`=1, `i_enable`=1:
  - `m_axis_tdata` 0x01..0x08 on consecutive cycles, first one cycle after the first `o_fifo_rd_en`.
  - `m_axis_tlast` on 0x04 and 0x08.
  - `o_packet_done` pulses the cycle after each of those beats.
- Same data, `m_axis_tready` toggling 1,0,0,1,0,1…:
  - All 8 words arrive in order with none lost.
  - `o_fifo_rd_en` never asserted while `occ`=2.
  - tdata/tvalid/tlast stable during every stall.
- `i_packet_len`=0, 3 words → `m_axis_tlast` on every beat, 3 `o_packet_done` pulses.
- `i_packet_len` changed from 4 to 2 after beat 1 → first packet still ends at beat 4. Next packet ends after 2 beats.
- `i_enable` dropped with `occ`=2 → exactly 2 more beats are delivered, then `m_axis_tvalid`=0 and `o_busy`=1 (packet open). Re-enabling resumes at the next word with the count continuing.
- `i_s_rst` asserted mid-packet with `occ`=2 → next cycle all outputs are at reset values. After release, a fresh packet's `m_axis_tlast` falls at beat `i_packet_len`.

Source files
------------

// File: rtl/fifo_axis_reader_if.sv
// AXI4-Stream bundle driven by fifo_axis_reader.
// The master modport is the stream source, slave is the consumer.
interface fifo_axis_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/fifo_axis_reader.sv
// Drains a FWFT FIFO into an AXI4-Stream master with fixed-length framing.
// A two-slot buffer keeps tready off the FIFO pop path at full rate.
module fifo_axis_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_s_rst,
    input  logic                  i_enable,
    input  logic [LEN_WIDTH-1:0]  i_packet_len,
    output logic                  o_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
    input  logic                  i_fifo_empty,
    fifo_axis_reader_if.master    m_axis,
    output logic                  o_packet_done,
    output logic                  o_busy
);

    logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
    logic [DATA_WIDTH-1:0] slot1_q, slot1_d;
    logic [1:0]            occ_q, occ_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic                  done_q, done_d;

    logic                  pop;
    logic                  hs;
    logic                  tvalid;
    logic                  tlast;
    logic [LEN_WIDTH-1:0]  len_sel;
    logic [LEN_WIDTH-1:0]  eff_len;

    assign pop    = i_enable & ~i_fifo_empty & (occ_q != 2'd2) & ~i_s_rst;
    assign tvalid = (occ_q != 2'd0);
    assign hs     = tvalid & m_axis.m_axis_tready;

    // Live length is only consulted before the first beat is accepted.
    assign len_sel = (beat_cnt_q == '0) ? i_packet_len : len_q;
    assign eff_len = (len_sel == '0) ? LEN_WIDTH'(1) : len_sel;
    assign tlast   = tvalid & (beat_cnt_q == eff_len - LEN_WIDTH'(1));

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        occ_d   = occ_q;
        case ({pop, hs})
            2'b10: begin
                if (occ_q == 2'd0) slot0_d = i_fifo_rd_data;
                else               slot1_d = i_fifo_rd_data;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                occ_d   = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    slot0_d = i_fifo_rd_data;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = i_fifo_rd_data;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        done_d     = hs & tlast;
        if (hs) begin
            if (beat_cnt_q == '0) len_d = eff_len;
            beat_cnt_d = tlast ? '0 : beat_cnt_q + LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            slot0_q    <= '0;
            slot1_q    <= '0;
            occ_q      <= 2'd0;
            beat_cnt_q <= '0;
            len_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
            occ_q      <= occ_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            done_q     <= done_d;
        end
    end

    assign o_fifo_rd_en         = pop;
    assign m_axis.m_axis_tdata  = slot0_q;
    assign m_axis.m_axis_tvalid = tvalid;
    assign m_axis.m_axis_tlast  = tlast;
    assign o_packet_done        = done_q;
    assign o_busy               = tvalid | (beat_cnt_q != '0);

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Bench for fifo_axis_reader: queue-based FIFO and stream model,
// directed scenarios followed by randomized traffic.
module tb_fifo_axis_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] pl;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        empty;
    logic        done;
    logic        busy;

    fifo_axis_reader_if #(.DATA_WIDTH(8)) axis ();

    fifo_axis_reader #(
        .DATA_WIDTH(8),
        .LEN_WIDTH (16)
    ) dut (
        .i_clk         (clk),
        .i_s_rst       (rst),
        .i_enable      (en),
        .i_packet_len  (pl),
        .o_fifo_rd_en  (rd_en),
        .i_fifo_rd_data(rd_data),
        .i_fifo_empty  (empty),
        .m_axis        (axis),
        .o_packet_done (done),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] fq[$];
    logic [7:0] mb[$];
    int         mbeat;
    int         mlen;
    bit         mdone;
    bit         just_rst;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // One clock cycle: inputs already set by caller at the falling edge.
    task automatic step();
        bit m_valid, m_last, m_pop, hs;
        int m_eff;
        empty   = (fq.size() == 0);
        rd_data = (fq.size() != 0) ? fq[0] : 8'hxx;
        #1;
        m_valid = (mb.size() != 0);
        if (mbeat == 0) m_eff = (pl == 0) ? 1 : int'(pl);
        else            m_eff = mlen;
        m_last = m_valid && (mbeat == m_eff - 1);
        m_pop  = en && (fq.size() != 0) && (mb.size() < 2) && !rst;
        check("rd_en", 32'(rd_en), 32'(m_pop));
        check("tvalid", 32'(axis.m_axis_tvalid), 32'(m_valid));
        check("tlast", 32'(axis.m_axis_tlast), 32'(m_last));
        check("done", 32'(done), 32'(mdone));
        check("busy", 32'(busy), 32'(m_valid || mbeat != 0));
        if (m_valid)
            check("tdata", 32'(axis.m_axis_tdata), 32'(mb[0]));
        else if (just_rst)
            check("tdata_rst", 32'(axis.m_axis_tdata), 32'h0);
        hs = m_valid && axis.m_axis_tready;
        @(posedge clk);
        #1;
        just_rst = rst;
        if (rst) begin
            mb.delete();
            mbeat = 0;
            mlen  = 0;
            mdone = 0;
        end else begin
            mdone = hs && m_last;
            if (hs) begin
                if (mbeat == 0) mlen = m_eff;
                void'(mb.pop_front());
                mbeat = m_last ? 0 : mbeat + 1;
            end
            if (m_pop) mb.push_back(fq.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) fq.push_back(8'(base + i));
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        pl  = 16'd4;
        axis.m_axis_tready = 1'b0;
        empty   = 1'b1;
        rd_data = 8'h00;
        mbeat = 0;
        mlen  = 0;
        mdone = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        just_rst = 1'b1;
        rst = 1'b0;
        step();

        // Back-to-back packets of four
        en = 1'b1;
        axis.m_axis_tready = 1'b1;
        load(8, 1);
        repeat (12) step();

        // Ready pattern 1,0,0,1,0,1 repeated
        load(8, 1);
        for (int i = 0; i < 30; i++) begin
            case (i % 6)
                1, 2, 4: axis.m_axis_tready = 1'b0;
                default: axis.m_axis_tready = 1'b1;
            endcase
            step();
        end
        axis.m_axis_tready = 1'b1;
        repeat (4) step();

        // Zero length means one beat per packet
        pl = 16'd0;
        load(3, 8'h30);
        repeat (6) step();

        // Length change mid-packet is ignored
        pl = 16'd4;
        load(6, 8'h40);
        for (int i = 0; i < 20; i++) begin
            if (mbeat >= 1) pl = 16'd2;
            step();
        end

        // Enable dropped with both slots full
        pl = 16'd8;
        load(6, 8'h50);
        axis.m_axis_tready = 1'b0;
        for (int i = 0; i < 10 && mb.size() < 2; i++) step();
        check("occ_full", 32'(mb.size()), 32'd2);
        en = 1'b0;
        axis.m_axis_tready = 1'b1;
        repeat (4) step();
        en = 1'b1;
        repeat (10) step();

        // Reset mid-packet with both slots full
        pl = 16'd3;
        load(6, 8'h60);
        step();
        step();
        axis.m_axis_tready = 1'b0;
        for (int i = 0; i < 10 && mb.size() < 2; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        axis.m_axis_tready = 1'b1;
        repeat (10) step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            axis.m_axis_tready = ($urandom_range(0, 3) != 0);
            en  = ($urandom_range(0, 7) != 0);
            pl  = 16'($urandom_range(0, 5));
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 2) != 0 && fq.size() < 16)
                fq.push_back(8'($urandom));
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
